// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher.
// Holds the FSM state encoding used by the top level. The 2'b11 code is
// never entered; the FSM treats it as IDLE so a corrupted state recovers.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_GAP  = 2'b10
    } ps_state_e;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event/status bundle of the pulse stretcher.
//   pulse_in  : single-cycle event strobe (producer -> stretcher)
//   retrig_en : 1 = an event while high extends the pulse, 0 = queue it
//   level_out : stretched level output
//   busy      : stretcher is in HIGH or GAP
//   pending   : queued events not yet replayed
//   overflow  : sticky flag, an event was dropped on a full queue
interface pulse_stretcher_if #(
    parameter int PEND_W = 2
);
    logic              pulse_in;
    logic              retrig_en;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output pulse_in, retrig_en,
        input  level_out, busy, pending, overflow
    );

    modport slave (
        input  pulse_in, retrig_en,
        output level_out, busy, pending, overflow
    );
endinterface

// File: rtl/pulse_stretcher_load_down_counter.sv
// Loadable down counter that stops at zero.
//   clk, rst : clock, async active-high reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; ignored at zero
//   count    : current value
//   zero     : count == 0
module load_down_counter #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns each single-cycle event on bus.pulse_in into a
// WIDTH_CYC-cycle level on bus.level_out, followed by a GAP_CYC-cycle low
// guard. Events arriving while busy are queued (pending) and replayed, or,
// with retrig_en while high, extend the current pulse.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of pulse_stretcher_if (see that file)
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int WIDTH_CYC = 8,
    parameter int GAP_CYC   = 4,
    parameter int CNT_W     = 25,
    parameter int PEND_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    pulse_stretcher_if.slave   bus
);
    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(WIDTH_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    ps_state_e         state_q, state_d;
    logic              level_q, level_d;
    logic              busy_q, busy_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;

    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_val, cnt;
    logic              queue_evt;
    logic [PEND_W:0]   eff;

    load_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Queued events plus an event landing on the GAP terminal edge.
    assign eff = {1'b0, pending_q} + (PEND_W+1)'(bus.pulse_in);

    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        queue_evt  = 1'b0;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.pulse_in) begin
                    state_d  = ST_HIGH;
                    cnt_load = 1'b1;
                    cnt_val  = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (bus.pulse_in && bus.retrig_en) begin
                    // Extension wins over the terminal transition.
                    cnt_load = 1'b1;
                    cnt_val  = HIGH_LOAD;
                end else begin
                    queue_evt = bus.pulse_in;
                    if (cnt_zero) begin
                        state_d  = ST_GAP;
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LOAD;
                    end else begin
                        cnt_dec = (cnt != '0);
                    end
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    // Increment and decrement net out through eff; the
                    // saturated-plus-one case fits because eff is one bit wider.
                    if (eff != '0) begin
                        state_d   = ST_HIGH;
                        cnt_load  = 1'b1;
                        cnt_val   = HIGH_LOAD;
                        pending_d = PEND_W'(eff - 1'b1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_dec   = 1'b1;
                    queue_evt = bus.pulse_in;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (queue_evt) begin
            if (pending_q == PEND_MAX) overflow_d = 1'b1;
            else                       pending_d  = pending_q + 1'b1;
        end

        // Outputs are registered copies of the next state.
        level_d = (state_d == ST_HIGH);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            busy_q     <= busy_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;
endmodule
